// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: walks IDLE/FETCH/DECODE/EXEC/HALT, owns PC and IR,
// and keeps a small return-address stack for JMP/RET call pairs.
module instr_fetch_seq #(
  parameter int         ADDR_W    = 10,
  parameter logic [5:0] OPC_JMP   = 6'b000110,
  parameter logic [5:0] OPC_RET   = 6'b000111,
  parameter int         RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       IR,
  output logic              CU_en,
  input  logic              bra,
  input  logic              hlt,
  input  logic [ADDR_W-1:0] BADR,
  input  logic              exec_done,
  output logic [ADDR_W-1:0] PC,
  output logic              halted,
  output logic              ras_ovf,
  output logic              ras_unf
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] DEPTH = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    HALT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [CW-1:0]     cnt;

  logic [5:0]        opc;
  logic              is_ret;
  logic              is_jmp;
  logic              empty;
  logic              full;
  logic              fire;
  logic              take_pop;
  logic              take_unf;
  logic              take_bra;
  logic              take_seq;
  logic [ADDR_W-1:0] pc_inc;
  logic [IW-1:0]     top_idx;
  logic [IW-1:0]     push_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   if (mem_valid) state_nx = DECODE;
      DECODE:  state_nx = EXEC;
      EXEC: begin
        if (hlt)            state_nx = HALT;
        else if (exec_done) state_nx = FETCH;
      end
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  assign mem_req  = (state == FETCH);
  assign CU_en    = (state == DECODE);
  assign halted   = (state == HALT);
  assign mem_addr = PC;

  assign opc      = IR[15:10];
  assign is_ret   = (opc == OPC_RET);
  assign is_jmp   = (opc == OPC_JMP);
  assign empty    = (cnt == '0);
  assign full     = (cnt == DEPTH);
  assign fire     = (state == EXEC) && !hlt && exec_done;
  assign pc_inc   = PC + ADDR_W'(1);
  assign top_idx  = IW'(cnt - ONE);
  assign push_idx = IW'(cnt);

  // Mutually exclusive next-PC selects; a pending RET outranks bra.
  assign take_pop = is_ret && !empty;
  assign take_unf = is_ret && empty;
  assign take_bra = !is_ret && bra;
  assign take_seq = !is_ret && !bra;

  always_ff @(posedge clk) begin
    if (rst) begin
      PC      <= '0;
      IR      <= '0;
      cnt     <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      if (state == IDLE && start) PC <= '0;
      if (state == FETCH && mem_valid) IR <= mem_rdata;
      if (fire) begin
        unique case (1'b1)
          take_pop: begin
            PC  <= ras[top_idx];
            cnt <= cnt - ONE;
          end
          take_unf: begin
            PC      <= pc_inc;
            ras_unf <= 1'b1;
          end
          take_bra: begin
            PC <= BADR;
            if (is_jmp && !full) begin
              ras[push_idx] <= pc_inc;
              cnt           <= cnt + ONE;
            end else if (is_jmp) begin
              ras_ovf <= 1'b1;
            end
          end
          take_seq: PC <= pc_inc;
          default:  PC <= pc_inc;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq: a queue-based PC/stack model predicts
// each fetch address, IR and sticky flag; a negedge monitor checks them.
module tb_instr_fetch_seq;

  localparam int AW = 10;
  localparam logic [5:0] JMP = 6'b000110;
  localparam logic [5:0] RET = 6'b000111;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_valid;
  logic [15:0]   mem_rdata;
  logic [15:0]   IR;
  logic          CU_en;
  logic          bra;
  logic          hlt;
  logic [AW-1:0] BADR;
  logic          exec_done;
  logic [AW-1:0] PC;
  logic          halted;
  logic          ras_ovf;
  logic          ras_unf;

  always #5 clk = ~clk;

  instr_fetch_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .IR(IR), .CU_en(CU_en),
    .bra(bra), .hlt(hlt), .BADR(BADR),
    .exec_done(exec_done), .PC(PC),
    .halted(halted), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  typedef struct {
    int addr;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ir_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  int          ref_pc;
  int          ref_ras[$];
  bit          ref_ovf;
  bit          ref_unf;
  logic [15:0] cur_word;
  bit          mon_on = 1'b0;

  logic        req_q = 1'b0;
  logic        cu_q  = 1'b0;
  logic [AW-1:0] last_addr = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  // Reference: next PC and stack effect of one retired instruction.
  task automatic model_exec(input logic [15:0] w, input bit b, input int badr);
    int inc;
    exp_t e;
    inc = (ref_pc + 1) % 1024;
    if (w[15:10] == RET) begin
      if (ref_ras.size() > 0) ref_pc = ref_ras.pop_back();
      else begin
        ref_unf = 1'b1;
        ref_pc  = inc;
      end
    end else if (b) begin
      if (w[15:10] == JMP) begin
        if (ref_ras.size() < 4) ref_ras.push_back(inc);
        else ref_ovf = 1'b1;
      end
      ref_pc = badr;
    end else begin
      ref_pc = inc;
    end
    e.addr = ref_pc;
    e.ovf  = ref_ovf;
    e.unf  = ref_unf;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (mem_req && !req_q) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_fetch: got addr %0h required none", mem_addr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("fetch_addr", 32'(mem_addr), e.addr);
          chk("ras_ovf", 32'(ras_ovf), 32'(e.ovf));
          chk("ras_unf", 32'(ras_unf), 32'(e.unf));
        end
      end else if (mem_req && req_q) begin
        chk("addr_stable", 32'(mem_addr), 32'(last_addr));
      end
      if (CU_en) begin
        if (cu_q) begin
          n_tests++;
          n_fail++;
          $display("FAIL cu_en_width: got 2+ cycles required 1");
        end
        if (ir_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_cu_en: got CU_en=1 required 0");
        end else begin
          chk("ir_word", 32'(IR), 32'(ir_q.pop_front()));
        end
      end
      req_q     = mem_req;
      cu_q      = CU_en;
      last_addr = mem_addr;
    end
  end

  function automatic logic [15:0] plain();
    logic [5:0] o;
    do o = 6'($urandom); while (o == JMP || o == RET);
    return {o, 10'($urandom)};
  endfunction

  task automatic do_start();
    exp_t e;
    start  = 1'b1;
    ref_pc = 0;
    e.addr = 0;
    e.ovf  = ref_ovf;
    e.unf  = ref_unf;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] w, input int lat);
    int k;
    k = 0;
    while (!mem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("fetch_wait", 32'(mem_req), 32'd1);
    repeat (lat) @(negedge clk);
    mem_valid = 1'b1;
    mem_rdata = w;
    cur_word  = w;
    ir_q.push_back(w);
    @(negedge clk);
    mem_valid = 1'($urandom_range(0, 1));
    mem_rdata = 16'($urandom);
  endtask

  task automatic execute(input bit b, input logic [AW-1:0] badr,
                         input int dly, input bit rnd_start);
    @(negedge clk);
    bra  = b;
    BADR = badr;
    hlt  = 1'b0;
    repeat (dly) begin
      mem_valid = 1'($urandom_range(0, 1));
      start     = rnd_start & 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    exec_done = 1'b1;
    model_exec(cur_word, b, int'(badr));
    @(negedge clk);
    exec_done = 1'b0;
    bra       = 1'b0;
    mem_valid = 1'b0;
    start     = 1'b0;
    BADR      = 10'($urandom);
  endtask

  task automatic instr(input logic [15:0] w, input int lat, input bit b,
                       input logic [AW-1:0] badr, input int dly);
    fetch(w, lat);
    execute(b, badr, dly, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] o;
    rst = 1'b1; start = 1'b1; mem_valid = 1'b1; mem_rdata = 16'hFFFF;
    bra = 1'b0; hlt = 1'b0; exec_done = 1'b0; BADR = '0;
    ref_ovf = 1'b0; ref_unf = 1'b0; ref_pc = 0; cur_word = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_cu_en",   32'(CU_en), 0);
    chk("rst_pc",      32'(PC), 0);
    chk("rst_ir",      32'(IR), 0);
    chk("rst_halted",  32'(halted), 0);
    chk("rst_ovf",     32'(ras_ovf), 0);
    chk("rst_unf",     32'(ras_unf), 0);
    rst = 1'b0; start = 1'b0; mem_valid = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    chk("idle_no_req", 32'(mem_req), 0);

    do_start();
    for (int i = 0; i < 3; i++) instr(plain(), 2, 1'b0, '0, 0);
    chk("seq_pc", 32'(PC), 3);

    instr(plain(), 1, 1'b1, 10'd5, 1);
    instr(plain(), 2, 1'b1, 10'h120, 0);
    chk("branch_pc", 32'(PC), 32'h120);
    instr(plain(), 0, 1'b1, 10'h3FF, 2);
    instr(plain(), 1, 1'b0, '0, 0);
    chk("wrap_pc", 32'(PC), 0);

    instr(plain(), 0, 1'b1, 10'h010, 0);
    instr({JMP, 10'($urandom)}, 1, 1'b1, 10'h200, 0);
    chk("call_pc", 32'(PC), 32'h200);
    instr({RET, 10'($urandom)}, 1, 1'b1, 10'h155, 1);
    chk("ret_pc", 32'(PC), 32'h011);

    for (int i = 0; i < 5; i++) begin
      instr({JMP, 10'($urandom)}, 0, 1'b1, 10'(10'h100 + i), 0);
      if (i == 3) chk("no_ovf_at_4", 32'(ras_ovf), 0);
    end
    chk("ovf_set", 32'(ras_ovf), 1);
    chk("ovf_taken", 32'(PC), 32'h104);
    for (int i = 0; i < 4; i++)
      instr({RET, 10'($urandom)}, 0, 1'($urandom_range(0, 1)), 10'($urandom), 0);
    chk("unwind_pc", 32'(PC), 32'h012);

    instr(plain(), 0, 1'b1, 10'd7, 0);
    instr({RET, 10'($urandom)}, 0, 1'b1, 10'h300, 0);
    chk("unf_set", 32'(ras_unf), 1);
    chk("unf_pc", 32'(PC), 8);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: o = JMP;
        3, 4:    o = RET;
        default: o = plain() >> 10;
      endcase
      fetch({o, 10'($urandom)}, $urandom_range(0, 4));
      execute(1'($urandom_range(0, 1)), 10'($urandom), $urandom_range(0, 3), 1'b1);
    end

    chk("pre_rst_fetch", 32'(mem_req), 1);
    rst = 1'b1; mem_valid = 1'b1; mem_rdata = 16'hABCD;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_req", 32'(mem_req), 0);
    chk("mid_rst_pc",  32'(PC), 0);
    chk("mid_rst_ir",  32'(IR), 0);
    chk("mid_rst_cu",  32'(CU_en), 0);
    chk("mid_rst_ovf", 32'(ras_ovf), 0);
    chk("mid_rst_unf", 32'(ras_unf), 0);
    @(negedge clk);
    chk("late_valid_cu", 32'(CU_en), 0);
    chk("late_valid_ir", 32'(IR), 0);
    mem_valid = 1'b0;
    ref_ras.delete();
    ref_ovf = 1'b0;
    ref_unf = 1'b0;
    do_start();
    instr(plain(), 1, 1'b0, '0, 0);
    instr({RET, 10'($urandom)}, 0, 1'b0, '0, 0);

    fetch(plain(), 1);
    @(negedge clk);
    hlt = 1'b1; exec_done = 1'b0; bra = 1'($urandom_range(0, 1));
    @(negedge clk);
    hlt = 1'b0; bra = 1'b0;
    chk("halt_flag", 32'(halted), 1);
    chk("halt_req",  32'(mem_req), 0);
    chk("halt_pc",   32'(PC), 32'(ref_pc));
    for (int i = 0; i < 10; i++) begin
      start     = 1'($urandom_range(0, 1));
      mem_valid = 1'($urandom_range(0, 1));
      exec_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halt_hold", 32'({halted, mem_req, CU_en}), 32'b100);
    end
    start = 1'b0; mem_valid = 1'b0; exec_done = 1'b0;
    chk("exp_drain", 32'(exp_q.size() + ir_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
